pe_row_ctrl: RTL
================

Name: pe_row_ctrl

Overview:
- Sequencer for a single processing element (PE) computing one 1-D convolution row, stride 1.
- Loads a FILTER_LEN-tap filter and maintains a sliding ifmap window.
- For each output, issues FILTER_LEN MAC beats to the PE, with an upstream partial sum as the PE's psum input.
- Collects the PE's psum result and presents it on a valid/ready output; sits between the memory/stream side and the PE.

Parameters:
- FILTER_LEN, 3, filter taps and window depth (≥2).
- DATA_SIZE, sizes::DATA_SIZE, filter/ifmap width, signed.
- BIGGER_DATA_SIZE, sizes::BIGGER_DATA_SIZE, psum width, signed.
- LEN_W, 8, width of the output-count field.

Ports:
- clk  in  1  clock, rising edge.
- n_rst  in  1  asynchronous active-low reset.
- start_i  in  1  begin a row job; honoured only in IDLE.
- ofmap_len_i  in  LEN_W  outputs in the row; sampled on an accepted start.
- busy_o  out  1  high whenever state≠IDLE.
- done_o  out  1  one-cycle pulse when the job completes.
- err_o  out  1  sticky: PE psum valid seen outside WAIT; cleared on accepted start.
- filt_valid_i / filt_ready_o / filt_data_i  in/out/in  1/1/DATA_SIZE  filter stream.
- ifmap_valid_i / ifmap_ready_o / ifmap_data_i  in/out/in  1/1/DATA_SIZE  ifmap stream.
- psin_valid_i / psin_ready_o / psin_data_i  in/out/in  1/1/BIGGER_DATA_SIZE  upstream psum, one per output.
- pe_filter_o  out  DATA_SIZE  to PE filter_i.
- pe_ifmap_o  out  DATA_SIZE  to PE ifmap_i.
- pe_psum_o  out  BIGGER_DATA_SIZE  to PE psum_i.
- pe_beat_o, pe_first_o, pe_last_o  out  1 each  beat valid / first beat / last beat.
- pe_psum_i  in  BIGGER_DATA_SIZE  from PE psum_o.
- pe_psum_valid_i  in  1  from PE psum_valid_o.
- out_valid_o / out_ready_i / out_data_o  out/in/out  1/1/BIGGER_DATA_SIZE  result stream.

Behaviour:
- Reset (async, any state): state=IDLE, all counters, window, filter and psum registers = 0; every output = 0.
- Handshake: a transfer occurs when valid && ready on a rising edge. Readys depend only on state and counters, never on valids. Source data is captured only on a transfer.
- IDLE:
  - start_i=1 latches ofmap_len_i, clears err_o and goes to LOAD_FILT.
  - If ofmap_len_i=0, it instead pulses done_o the next cycle and stays IDLE.
- LOAD_FILT: filt_ready_o=1; tap k stored in arrival order (k=0 first). After FILTER_LEN transfers → GATHER.
- GATHER:
  - ifmap_ready_o=1 while window count<FILTER_LEN; new words are appended at the newest end.
  - psin_ready_o=1 until one psum is held; it is held for the current output.
  - Both may transfer in the same cycle. When the window is full and the psum is held → ISSUE next cycle.
- ISSUE: exactly FILTER_LEN consecutive cycles, k=0..FILTER_LEN-1, with:
  - pe_beat_o=1
  - pe_filter_o=filt[k]
  - pe_ifmap_o=win[k] (win[0] oldest)
  - pe_psum_o=held psum, constant for all beats
  - pe_first_o=(k==0), pe_last_o=(k==FILTER_LEN-1)
  - Then → WAIT.
- Outside ISSUE: pe_beat_o/first/last=0; pe_filter_o, pe_ifmap_o and pe_psum_o hold their last values.
- WAIT: on pe_psum_valid_i=1, capture pe_psum_i into out_data_o → OUT. There is no timeout.
- pe_psum_valid_i in any state other than WAIT is ignored for data and sets err_o.
- OUT:
  - out_valid_o=1; out_data_o stable until accepted.
  - On transfer with outputs remaining: drop win[0], window count=FILTER_LEN-1, psum slot freed, output counter+1 → GATHER.
  - On transfer of the last output: done_o pulses the next cycle, → IDLE.
- Counters: output counter is LEN_W wide (max 2^LEN_W−1 outputs, no wrap within a job). Beat and window counters are sized ceil(log2(FILTER_LEN+1)).
- Throughput: with all valids/readys high, one output per FILTER_LEN+1+PE latency+1 cycles after the initial window fill.
- start_i while busy_o=1 is ignored.

Test Plan:
- Reference PE model: psum_o=psum_i+Σ filter·ifmap over beats first..last, psum_valid_o one cycle after the last beat.
- Basic row: FILTER_LEN=3, filter {1,2,3}, ifmap {1,2,3,4,5}, psin {0,0,0}, ofmap_len=3, all valids/readys high → out 14, 20, 26; done_o one pulse after the third transfer; ifmap transfers=5.
- Signed and bias: filter {−1,2,−3}, ifmap {4,−5,6}, psin {100}, ofmap_len=1 → pe_first_o/pe_last_o on beats 0/2, out = 100−4−10−18 = 68.
- Backpressure: basic row with out_ready_i low 5 cycles per output and random valid gaps on ifmap/psin → same values in order; out_data_o stable while stalled; no beat issued before the window is full.
- Error and ignore: pulse pe_psum_valid_i during ISSUE, and start_i during the job → err_o=1 sticky, results unchanged, job continues; the next accepted start clears err_o.
- Reset and corners: assert n_rst mid-ISSUE → all outputs 0 immediately, IDLE. ofmap_len=0 → done_o next cycle, no readys asserted.

Source files
------------

// File: rtl/sizes.sv
// rtl/sizes.sv - shared datapath widths for the PE row sequencer
package sizes;
   localparam int DATA_SIZE        = 8;
   localparam int BIGGER_DATA_SIZE = 20;
endpackage

// File: rtl/pe_row_ctrl_if.sv
// rtl/pe_row_ctrl_if.sv - stream and PE-side signals of the PE row sequencer
interface pe_row_ctrl_if #(
   parameter int DATA_SIZE        = sizes::DATA_SIZE,
   parameter int BIGGER_DATA_SIZE = sizes::BIGGER_DATA_SIZE
);
   logic                        filt_valid_i;
   logic                        filt_ready_o;
   logic [DATA_SIZE-1:0]        filt_data_i;
   logic                        ifmap_valid_i;
   logic                        ifmap_ready_o;
   logic [DATA_SIZE-1:0]        ifmap_data_i;
   logic                        psin_valid_i;
   logic                        psin_ready_o;
   logic [BIGGER_DATA_SIZE-1:0] psin_data_i;
   logic [DATA_SIZE-1:0]        pe_filter_o;
   logic [DATA_SIZE-1:0]        pe_ifmap_o;
   logic [BIGGER_DATA_SIZE-1:0] pe_psum_o;
   logic                        pe_beat_o;
   logic                        pe_first_o;
   logic                        pe_last_o;
   logic [BIGGER_DATA_SIZE-1:0] pe_psum_i;
   logic                        pe_psum_valid_i;
   logic                        out_valid_o;
   logic                        out_ready_i;
   logic [BIGGER_DATA_SIZE-1:0] out_data_o;

   // sequencer side
   modport master (
      input  filt_valid_i, filt_data_i, ifmap_valid_i, ifmap_data_i,
      input  psin_valid_i, psin_data_i, pe_psum_i, pe_psum_valid_i, out_ready_i,
      output filt_ready_o, ifmap_ready_o, psin_ready_o,
      output pe_filter_o, pe_ifmap_o, pe_psum_o, pe_beat_o, pe_first_o, pe_last_o,
      output out_valid_o, out_data_o
   );

   // memory/stream/PE side
   modport slave (
      output filt_valid_i, filt_data_i, ifmap_valid_i, ifmap_data_i,
      output psin_valid_i, psin_data_i, pe_psum_i, pe_psum_valid_i, out_ready_i,
      input  filt_ready_o, ifmap_ready_o, psin_ready_o,
      input  pe_filter_o, pe_ifmap_o, pe_psum_o, pe_beat_o, pe_first_o, pe_last_o,
      input  out_valid_o, out_data_o
   );
endinterface

// File: rtl/pe_row_ctrl.sv
// rtl/pe_row_ctrl.sv - sequencer feeding one PE for a stride-1 1-D convolution row
module pe_row_ctrl #(
   parameter int FILTER_LEN       = 3,
   parameter int DATA_SIZE        = sizes::DATA_SIZE,
   parameter int BIGGER_DATA_SIZE = sizes::BIGGER_DATA_SIZE,
   parameter int LEN_W            = 8
) (
   input  logic             clk,
   input  logic             n_rst,
   input  logic             start_i,
   input  logic [LEN_W-1:0] ofmap_len_i,
   output logic             busy_o,
   output logic             done_o,
   output logic             err_o,
   pe_row_ctrl_if.master    bus
);

   localparam int CNT_W = $clog2(FILTER_LEN + 1);
   localparam logic [CNT_W-1:0] FL_C   = CNT_W'(FILTER_LEN);
   localparam logic [CNT_W-1:0] LAST_C = CNT_W'(FILTER_LEN - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD_FILT,
      S_GATHER,
      S_ISSUE,
      S_WAIT,
      S_OUT
   } state_e;

   typedef logic [DATA_SIZE-1:0] data_t;
   typedef logic [BIGGER_DATA_SIZE-1:0] psum_t;

   state_e           state_q, state_d;
   logic [LEN_W-1:0] len_q, len_d;
   logic [LEN_W-1:0] out_cnt_q, out_cnt_d;
   // beat index while issuing; reused as the tap index while loading the filter
   logic [CNT_W-1:0] beat_q, beat_d;
   logic [CNT_W-1:0] win_cnt_q, win_cnt_d;
   data_t            filt_q [FILTER_LEN];
   data_t            filt_d [FILTER_LEN];
   data_t            win_q  [FILTER_LEN];
   data_t            win_d  [FILTER_LEN];
   psum_t            psum_q, psum_d;
   logic             held_q, held_d;
   psum_t            out_data_q, out_data_d;
   logic             done_q, done_d;
   logic             err_q, err_d;
   data_t            pe_filter_q, pe_filter_d;
   data_t            pe_ifmap_q, pe_ifmap_d;
   psum_t            pe_psum_q, pe_psum_d;
   logic             pe_beat_q, pe_beat_d;
   logic             pe_first_q, pe_first_d;
   logic             pe_last_q, pe_last_d;

   logic filt_rdy, ifmap_rdy, psin_rdy, out_vld;
   logic filt_xfer, ifmap_xfer, psin_xfer, out_xfer;

   // readys come from state and counters only, never from the valids
   always_comb begin
      filt_rdy   = (state_q == S_LOAD_FILT);
      ifmap_rdy  = (state_q == S_GATHER) && (win_cnt_q < FL_C);
      psin_rdy   = (state_q == S_GATHER) && !held_q;
      out_vld    = (state_q == S_OUT);
      filt_xfer  = filt_rdy  && bus.filt_valid_i;
      ifmap_xfer = ifmap_rdy && bus.ifmap_valid_i;
      psin_xfer  = psin_rdy  && bus.psin_valid_i;
      out_xfer   = out_vld   && bus.out_ready_i;
   end

   // next-state and datapath updates; PE-facing outputs are registered one step
   // ahead so that they line up with the ISSUE beat they belong to
   always_comb begin
      state_d     = state_q;
      len_d       = len_q;
      out_cnt_d   = out_cnt_q;
      beat_d      = beat_q;
      win_cnt_d   = win_cnt_q;
      filt_d      = filt_q;
      win_d       = win_q;
      psum_d      = psum_q;
      held_d      = held_q;
      out_data_d  = out_data_q;
      done_d      = 1'b0;
      err_d       = err_q || (bus.pe_psum_valid_i && (state_q != S_WAIT));
      pe_filter_d = pe_filter_q;
      pe_ifmap_d  = pe_ifmap_q;
      pe_psum_d   = pe_psum_q;
      pe_beat_d   = 1'b0;
      pe_first_d  = 1'b0;
      pe_last_d   = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               // a stray PE valid in the same cycle still counts against the new job
               err_d = bus.pe_psum_valid_i;
               if (ofmap_len_i == '0) begin
                  done_d = 1'b1;
               end else begin
                  len_d     = ofmap_len_i;
                  out_cnt_d = '0;
                  beat_d    = '0;
                  win_cnt_d = '0;
                  held_d    = 1'b0;
                  state_d   = S_LOAD_FILT;
               end
            end
         end
         S_LOAD_FILT: begin
            if (filt_xfer) begin
               filt_d[beat_q] = bus.filt_data_i;
               if (beat_q == LAST_C) begin
                  beat_d  = '0;
                  state_d = S_GATHER;
               end else begin
                  beat_d = beat_q + 1'b1;
               end
            end
         end
         S_GATHER: begin
            if (ifmap_xfer) begin
               win_d[win_cnt_q] = bus.ifmap_data_i;
               win_cnt_d        = win_cnt_q + 1'b1;
            end
            if (psin_xfer) begin
               psum_d = bus.psin_data_i;
               held_d = 1'b1;
            end
            if ((win_cnt_d == FL_C) && held_d) begin
               beat_d  = '0;
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (beat_q == LAST_C) begin
               beat_d  = '0;
               state_d = S_WAIT;
            end else begin
               beat_d = beat_q + 1'b1;
            end
         end
         S_WAIT: begin
            if (bus.pe_psum_valid_i) begin
               out_data_d = bus.pe_psum_i;
               state_d    = S_OUT;
            end
         end
         S_OUT: begin
            if (out_xfer) begin
               if ((out_cnt_q + LEN_W'(1)) == len_q) begin
                  done_d  = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  // slide by one: the oldest word leaves, one new word is needed
                  for (int i = 0; i < FILTER_LEN - 1; i++) begin
                     win_d[i] = win_q[i+1];
                  end
                  win_d[FILTER_LEN-1] = '0;
                  win_cnt_d = LAST_C;
                  held_d    = 1'b0;
                  out_cnt_d = out_cnt_q + LEN_W'(1);
                  state_d   = S_GATHER;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (state_d == S_ISSUE) begin
         pe_beat_d   = 1'b1;
         pe_first_d  = (beat_d == '0);
         pe_last_d   = (beat_d == LAST_C);
         pe_filter_d = filt_d[beat_d];
         pe_ifmap_d  = win_d[beat_d];
         pe_psum_d   = psum_d;
      end
   end

   // state and datapath registers, cleared asynchronously
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q     <= S_IDLE;
         len_q       <= '0;
         out_cnt_q   <= '0;
         beat_q      <= '0;
         win_cnt_q   <= '0;
         for (int i = 0; i < FILTER_LEN; i++) begin
            filt_q[i] <= '0;
            win_q[i]  <= '0;
         end
         psum_q      <= '0;
         held_q      <= 1'b0;
         out_data_q  <= '0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         pe_filter_q <= '0;
         pe_ifmap_q  <= '0;
         pe_psum_q   <= '0;
         pe_beat_q   <= 1'b0;
         pe_first_q  <= 1'b0;
         pe_last_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         len_q       <= len_d;
         out_cnt_q   <= out_cnt_d;
         beat_q      <= beat_d;
         win_cnt_q   <= win_cnt_d;
         filt_q      <= filt_d;
         win_q       <= win_d;
         psum_q      <= psum_d;
         held_q      <= held_d;
         out_data_q  <= out_data_d;
         done_q      <= done_d;
         err_q       <= err_d;
         pe_filter_q <= pe_filter_d;
         pe_ifmap_q  <= pe_ifmap_d;
         pe_psum_q   <= pe_psum_d;
         pe_beat_q   <= pe_beat_d;
         pe_first_q  <= pe_first_d;
         pe_last_q   <= pe_last_d;
      end
   end

   assign busy_o            = (state_q != S_IDLE);
   assign done_o            = done_q;
   assign err_o             = err_q;
   assign bus.filt_ready_o  = filt_rdy;
   assign bus.ifmap_ready_o = ifmap_rdy;
   assign bus.psin_ready_o  = psin_rdy;
   assign bus.out_valid_o   = out_vld;
   assign bus.out_data_o    = out_data_q;
   assign bus.pe_filter_o   = pe_filter_q;
   assign bus.pe_ifmap_o    = pe_ifmap_q;
   assign bus.pe_psum_o     = pe_psum_q;
   assign bus.pe_beat_o     = pe_beat_q;
   assign bus.pe_first_o    = pe_first_q;
   assign bus.pe_last_o     = pe_last_q;

endmodule
